tx_serializer: RTL and testbench
================================

Name: tx_serializer

Overview:
- Serial link transmitter for the NoC source path.
- Accepts one parallel flit (payload plus destination address) from a traffic source on a request strobe and shifts it onto a 1-bit serial line. The frame is a start bit followed by the data bits, LSB first.
- Reports its own busy state upstream to throttle the source.
- Waits for the downstream channel to be free before starting a frame.

Parameters:
- DATA_W, default 16 (PAYLOAD_SIZE 12 + ADDR_SZ 4): flit width in bits. Must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset; asynchronous, active-high. Clock is clk.
- req  in  1  request strobe from the source: "data is valid, send it". Sampled on each rising edge.
- tx_busy  out  1  registered. High from flit acceptance until the frame completes. The source must not issue req while it is high.
- busy  in  1  downstream channel busy. Gates the start of a frame only.
- data  in  DATA_W  flit. Bits [ADDR_SZ-1:0] hold the destination; the upper bits hold the payload/source id.
- serial_out  out  1  serial line. Idle level is 0.
- tx_active  out  1  high while the start bit or any data bit is on serial_out.

Behaviour:
- Reset values: tx_busy=0, serial_out=0, tx_active=0, state=IDLE. The shift register and bit counter are cleared.
- Reset asserted mid-frame aborts the frame immediately. Outputs go to their reset values; no partial completion.
- States: IDLE, ARM, SHIFT, STOP. All outputs are registered.
- IDLE:
  - If req=1 at an edge, capture data into the shift register, set tx_busy<=1, and go to ARM.
  - Otherwise hold serial_out=0 and tx_active=0.
- ARM:
  - If busy=0, set serial_out<=1 (start bit), tx_active<=1, count<=0, and go to SHIFT.
  - If busy=1, stay in ARM with serial_out=0. The wait is indefinite.
- SHIFT:
  - Each edge, serial_out<=shreg[0], the shift register shifts right, and count increments.
  - After DATA_W data bits have been driven, go to STOP.
  - busy is ignored once the start bit has been sent.
- STOP: serial_out<=0, tx_active<=0, tx_busy<=0, then go to IDLE.
- req is ignored whenever the state is not IDLE. No queueing: a strobe arriving while busy is dropped.
- req is edge-sampled, not held. A 1-cycle pulse suffices, and a held req does not retrigger until the block is back in IDLE.
- req=1 in the cycle tx_busy falls is not accepted, because the state is STOP. It is first accepted in the following cycle.
- Timing, with req sampled at edge k and busy=0:
  - tx_busy=1 after edge k.
  - Start bit after edge k+1.
  - Data bit i after edge k+2+i.
  - Line returns to 0 and tx_busy=0 after edge k+2+DATA_W.
  - Frame length is DATA_W+1 high-capable cycles.
- Each cycle spent in ARM with busy=1 delays all of the above by one cycle.
- The data input is not required to be stable after the capture edge.

Decomposition:
- Shared package noc_pkg:
  - PAYLOAD_SIZE, ADDR_SZ, NUM_NODES.
  - Derived FLIT_W = PAYLOAD_SIZE+ADDR_SZ.
  - State enum tx_state_t.
- Single module, no sub-modules needed. The bit counter is $clog2(DATA_W+1) wide.

Test Plan:
- Reset with req=1 held -> all outputs 0 during reset. Capture happens on the first edge after release.
- Pulse req 1 cycle with data=16'hA5C3, busy=0 -> serial_out sequence 1 (start), then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB first), then 0. tx_active high for exactly 17 cycles. tx_busy high for 18 cycles.
- busy=1 for 5 cycles after capture of 16'h0001 -> serial_out stays 0 in ARM. Start bit follows the edge after busy falls. Raising busy mid-frame changes nothing.
- Second req pulse (16'hFFFF) while tx_busy=1 -> ignored; only the first flit is transmitted. The same req re-issued the cycle after tx_busy falls -> transmitted.
- Back-to-back: req asserted the cycle after tx_busy deasserts -> the new frame starts with at least one idle-0 cycle between frames. Both frames are correct.
- Assert reset in the middle of data bit 7 -> serial_out, tx_active, and tx_busy go 0 asynchronously. A next req after release sends a full clean frame.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry and the serial transmitter state encoding.
package noc_pkg;

  localparam int PAYLOAD_SIZE = 12;
  localparam int ADDR_SZ      = 4;
  localparam int NUM_NODES    = 16;
  localparam int FLIT_W       = PAYLOAD_SIZE + ADDR_SZ;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Destination sits in the low bits so it leaves the serializer first.
  typedef struct packed {
    logic [PAYLOAD_SIZE-1:0] payload;
    logic [ADDR_SZ-1:0]      dest;
  } flit_t;

endpackage

// File: rtl/tx_serializer.sv
// Flit-to-serial transmitter: start bit then DATA_W bits LSB first; frame starts 2 edges after req.
// Holds in ARM while downstream busy=1; tx_busy throttles the source until the frame completes.
module tx_serializer
  import noc_pkg::*;
#(
  parameter int DATA_W = FLIT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              tx_busy,
  input  logic              busy,
  input  logic [DATA_W-1:0] data,
  output logic              serial_out,
  output logic              tx_active
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_ARM   = 2'(ARM);
  localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
  localparam logic [1:0] ST_STOP  = 2'(STOP);

  logic [1:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      count      <= '0;
      tx_busy    <= 1'b0;
      serial_out <= 1'b0;
      tx_active  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          serial_out <= 1'b0;
          tx_active  <= 1'b0;
          if (req) begin
            shreg   <= data;
            tx_busy <= 1'b1;
            state   <= ST_ARM;
          end
        end
        ST_ARM: begin
          // Downstream busy only gates the start bit; once launched the frame runs to completion.
          if (!busy) begin
            serial_out <= 1'b1;
            tx_active  <= 1'b1;
            count      <= '0;
            state      <= ST_SHIFT;
          end else begin
            serial_out <= 1'b0;
          end
        end
        ST_SHIFT: begin
          serial_out <= shreg[0];
          shreg      <= shreg >> 1;
          count      <= count + CNT_W'(1);
          if (count == LAST_BIT) begin
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          serial_out <= 1'b0;
          tx_active  <= 1'b0;
          tx_busy    <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: scoreboard of expected line bits checked against serial_out.
module tb_tx_serializer;
  import noc_pkg::*;

  localparam int DATA_W = FLIT_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              req;
  logic              busy;
  logic [DATA_W-1:0] data;
  logic              tx_busy;
  logic              serial_out;
  logic              tx_active;

  tx_serializer #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .data       (data),
    .serial_out (serial_out),
    .tx_active  (tx_active)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit exp_q[$];
  int exp_busy_len = 18;
  int act_run = 0;
  int busy_run = 0;
  logic prev_act = 1'b0;
  logic prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected line image of one frame: start bit, then data LSB first.
  task automatic push_frame(input logic [DATA_W-1:0] d);
    exp_q.push_back(1'b1);
    for (int i = 0; i < DATA_W; i++) exp_q.push_back(d[i]);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (tx_busy !== 1'b0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < max_cycles), 1);
  endtask

  // Line monitor: pops the scoreboard while tx_active, and checks frame/busy lengths.
  always @(negedge clk) begin
    if (reset) begin
      act_run   = 0;
      busy_run  = 0;
      prev_act  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (tx_active) begin
        check("bit_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("serial_bit", 32'(serial_out), 32'(exp_q.pop_front()));
        act_run++;
      end else begin
        check("idle_low", 32'(serial_out), 0);
        if (prev_act) begin
          check("active_len", act_run, DATA_W + 1);
          act_run = 0;
        end
      end
      if (tx_busy) begin
        busy_run++;
      end else if (prev_busy) begin
        check("busy_len", busy_run, exp_busy_len);
        busy_run = 0;
      end
      prev_act  = tx_active;
      prev_busy = tx_busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with req asserted: outputs stay low, capture on first edge after release.
    reset = 1'b1;
    req   = 1'b1;
    busy  = 1'b0;
    data  = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_tx_busy", 32'(tx_busy), 0);
    check("rst_serial_out", 32'(serial_out), 0);
    check("rst_tx_active", 32'(tx_active), 0);
    reset = 1'b0;
    push_frame(16'h1234);
    exp_busy_len = 18;
    @(posedge clk);
    #1;
    check("first_edge_capture", 32'(tx_busy), 1);
    req  = 1'b0;
    data = '1;
    wait_idle(60);
    check("q_drained_rst", exp_q.size(), 0);

    // Single pulse, known pattern.
    @(negedge clk);
    req  = 1'b1;
    data = 16'hA5C3;
    push_frame(16'hA5C3);
    exp_busy_len = 18;
    @(negedge clk);
    req  = 1'b0;
    data = 16'h0000;
    check("a5c3_busy_up", 32'(tx_busy), 1);
    wait_idle(60);
    check("q_drained_a5c3", exp_q.size(), 0);

    // Downstream busy stalls the start for 5 cycles, then toggles mid-frame.
    @(negedge clk);
    req  = 1'b1;
    busy = 1'b1;
    data = 16'h0001;
    push_frame(16'h0001);
    exp_busy_len = 18 + 5;
    @(negedge clk);
    req = 1'b0;
    repeat (5) begin
      check("arm_line_low", 32'(serial_out), 0);
      check("arm_busy_high", 32'(tx_busy), 1);
      @(negedge clk);
    end
    busy = 1'b0;
    repeat (4) @(negedge clk);
    busy = 1'b1;
    wait_idle(60);
    busy = 1'b0;
    check("q_drained_stall", exp_q.size(), 0);

    // Strobe while busy is dropped; req held from the STOP cycle is taken one edge later.
    @(negedge clk);
    req  = 1'b1;
    data = 16'h1357;
    push_frame(16'h1357);
    exp_busy_len = 18;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    req  = 1'b1;
    data = 16'hFFFF;
    @(negedge clk);
    req = 1'b0;
    repeat (13) @(negedge clk);
    check("in_stop_busy", 32'(tx_busy), 1);
    req  = 1'b1;
    data = 16'h2468;
    push_frame(16'h2468);
    @(negedge clk);
    check("stop_req_ignored", 32'(tx_busy), 0);
    @(negedge clk);
    check("req_after_fall", 32'(tx_busy), 1);
    req = 1'b0;
    wait_idle(60);
    check("q_drained_drop", exp_q.size(), 0);

    // Back-to-back frames, second request issued right as tx_busy falls.
    @(negedge clk);
    req  = 1'b1;
    data = 16'h0F0F;
    push_frame(16'h0F0F);
    @(negedge clk);
    req = 1'b0;
    wait_idle(60);
    check("gap_line_low", 32'(serial_out), 0);
    req  = 1'b1;
    data = 16'hF0F0;
    push_frame(16'hF0F0);
    @(negedge clk);
    req = 1'b0;
    wait_idle(60);
    check("q_drained_b2b", exp_q.size(), 0);

    // Reset during data bit 7 aborts the frame asynchronously.
    @(negedge clk);
    req  = 1'b1;
    data = 16'hACE1;
    push_frame(16'hACE1);
    @(negedge clk);
    req = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_active", 32'(tx_active), 1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_serial_out", 32'(serial_out), 0);
    check("abort_tx_active", 32'(tx_active), 0);
    check("abort_tx_busy", 32'(tx_busy), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_abort_idle", 32'(tx_busy), 0);
    req  = 1'b1;
    data = 16'h5A5A;
    push_frame(16'h5A5A);
    exp_busy_len = 18;
    @(negedge clk);
    req = 1'b0;
    wait_idle(60);
    check("q_drained_abort", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
